// File: rtl/input_flow_control.sv
// input_flow_control: receive-side val/ret link buffer with an FWFT empty/rd read port.
//   clk      - system clock, rising edge
//   rst_n    - asynchronous active-low reset
//   val      - upstream presents a flit on data_in
//   data_in  - flit from upstream
//   ret      - buffer full, upstream must hold val low
//   rd       - local consumer pops the head flit
//   data_out - head flit, valid while empty=0
//   empty    - no flit buffered
//   count    - number of buffered flits, 0..DEPTH
//   ovf_err  - sticky: a flit arrived while ret=1
//   udf_err  - sticky: rd asserted while empty=1
module input_flow_control #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4,
    parameter int ADDR_WIDTH = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  val,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic                  ret,
    input  logic                  rd,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  ovf_err,
    output logic                  udf_err
);
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic                  ovf_q, ovf_d, udf_q, udf_d;
    logic                  wr_en, rd_en;

    // full/empty come from the registered count only, so ret has no path from val or rd
    assign ret      = count_q == (ADDR_WIDTH+1)'(DEPTH);
    assign empty    = count_q == '0;
    assign data_out = mem_q[rd_ptr_q];
    assign count    = count_q;
    assign ovf_err  = ovf_q;
    assign udf_err  = udf_q;

    always_comb begin
        wr_en    = val && !ret;
        rd_en    = rd && !empty;
        // pointers are exactly ADDR_WIDTH bits, so the increment wraps modulo DEPTH
        wr_ptr_d = wr_en ? wr_ptr_q + ADDR_WIDTH'(1) : wr_ptr_q;
        rd_ptr_d = rd_en ? rd_ptr_q + ADDR_WIDTH'(1) : rd_ptr_q;
        count_d  = (wr_en && !rd_en) ? count_q + (ADDR_WIDTH+1)'(1) :
                   (rd_en && !wr_en) ? count_q - (ADDR_WIDTH+1)'(1) : count_q;
        ovf_d    = ovf_q || (val && ret);
        udf_d    = udf_q || (rd && empty);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    // storage needs no reset; its contents are don't-care until written
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= data_in;
    end
endmodule

// File: tb/tb_input_flow_control.sv
// tb_input_flow_control: directed self-checking bench for input_flow_control.
module tb_input_flow_control;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        val = 1'b0;
    logic [31:0] data_in = '0;
    logic        ret;
    logic        rd = 1'b0;
    logic [31:0] data_out;
    logic        empty;
    logic [2:0]  count;
    logic        ovf_err;
    logic        udf_err;
    int          n_run = 0;
    int          n_fail = 0;

    input_flow_control #(.DATA_WIDTH(32), .DEPTH(4), .ADDR_WIDTH(2)) dut (
        .clk(clk), .rst_n(rst_n), .val(val), .data_in(data_in), .ret(ret), .rd(rd),
        .data_out(data_out), .empty(empty), .count(count), .ovf_err(ovf_err), .udf_err(udf_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_run++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // advance one edge and settle just after it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2;
        chk("rst_count", 32'(count), 0);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_ret", 32'(ret), 0);
        chk("rst_ovf", 32'(ovf_err), 0);
        chk("rst_udf", 32'(udf_err), 0);
        step();
        rst_n = 1'b1;
        step();
        // fill to full
        for (int i = 0; i < 4; i++) begin
            val = 1'b1;
            data_in = 32'hA0 + 32'(i);
            step();
            chk("fill_count", 32'(count), 32'(i + 1));
            chk("fill_empty", 32'(empty), 0);
            chk("fill_head", data_out, 32'hA0);
            chk("fill_ret", 32'(ret), (i == 3) ? 32'd1 : 32'd0);
        end
        // overflow at full: flit dropped
        data_in = 32'hFF;
        step();
        chk("ovf_flag", 32'(ovf_err), 1);
        chk("ovf_count", 32'(count), 4);
        chk("ovf_ret", 32'(ret), 1);
        chk("ovf_head", data_out, 32'hA0);
        // simultaneous val+rd at full: read proceeds, write blocked
        rd = 1'b1;
        step();
        chk("sim_count", 32'(count), 3);
        chk("sim_ret", 32'(ret), 0);
        chk("sim_head", data_out, 32'hA1);
        chk("sim_ovf", 32'(ovf_err), 1);
        // drain remaining flits in order; 0xFF must never appear
        val = 1'b0;
        for (int i = 1; i < 4; i++) begin
            chk("drain_data", data_out, 32'hA0 + 32'(i));
            step();
        end
        chk("drain_empty", 32'(empty), 1);
        chk("drain_count", 32'(count), 0);
        chk("drain_udf", 32'(udf_err), 0);
        // underflow with simultaneous write
        val = 1'b1;
        data_in = 32'h55;
        step();
        chk("udf_flag", 32'(udf_err), 1);
        chk("udf_count", 32'(count), 1);
        chk("udf_head", data_out, 32'h55);
        chk("udf_empty", 32'(empty), 0);
        // pop 0x55, then preload 0x00 and stream
        val = 1'b0;
        step();
        chk("pop_count", 32'(count), 0);
        rd = 1'b0;
        val = 1'b1;
        data_in = 32'h00;
        step();
        chk("pre_count", 32'(count), 1);
        rd = 1'b1;
        for (int i = 0; i < 10; i++) begin
            chk("stream_data", data_out, 32'(i));
            data_in = 32'(i + 1);
            step();
            chk("stream_count", 32'(count), 1);
            chk("stream_ret", 32'(ret), 0);
        end
        chk("stream_last", data_out, 32'h0A);
        // build count=3 then reset mid-cycle
        rd = 1'b0;
        for (int i = 0; i < 2; i++) begin
            data_in = 32'h30 + 32'(i);
            step();
        end
        val = 1'b0;
        chk("pre_rst_count", 32'(count), 3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_count", 32'(count), 0);
        chk("arst_empty", 32'(empty), 1);
        chk("arst_ret", 32'(ret), 0);
        chk("arst_ovf", 32'(ovf_err), 0);
        chk("arst_udf", 32'(udf_err), 0);
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule

// File: doc/input_flow_control.md
Name: input_flow_control

Overview:
- Receive-side counterpart of the router output-port flow control.
- Accepts flits from the upstream neighbour on a val/ret link, buffers them in a small FIFO, and drives ret=1 back upstream when the buffer cannot accept a flit.
- Presents buffered flits to the local router logic through an empty/rd first-word-fall-through interface.
- One instance per router input port.

Parameters:
- DATA_WIDTH, 32, flit width in bits.
- DEPTH, 4, FIFO entries; must be a power of 2 and at least 2.
- ADDR_WIDTH, 2, log2(DEPTH); pointer width.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- val  input  1  upstream neighbour presents a valid flit on data_in this cycle.
- data_in  input  DATA_WIDTH  flit from the upstream neighbour.
- ret  output  1  1 = buffer full; the upstream neighbour must hold val low.
- rd  input  1  local consumer pops the head flit this cycle.
- data_out  output  DATA_WIDTH  head flit, valid whenever empty=0.
- empty  output  1  1 = no flit buffered.
- count  output  ADDR_WIDTH+1  number of buffered flits, 0..DEPTH.
- ovf_err  output  1  sticky flag: a flit arrived while ret=1.
- udf_err  output  1  sticky flag: rd was asserted while empty=1.

Behaviour:
- Reset (async, rst_n=0): wr_ptr=0, rd_ptr=0, count=0, ovf_err=0, udf_err=0. Consequently empty=1, ret=0, data_out=storage[0]; storage contents are don't-care. Reset takes effect immediately, including mid-transfer; any in-flight flit is lost.
- ret = (count == DEPTH), decoded from registered count, with no combinational path from val or rd.
  - The upstream sender computes val = !empty_up && !ret and pops its own FIFO in the same cycle, so a transfer completes in the single cycle where val=1 and ret=0.
- Write: when val=1 and ret=0, data_in is stored at wr_ptr, and wr_ptr increments modulo DEPTH on the next edge.
- Read: when rd=1 and empty=0, rd_ptr increments modulo DEPTH. data_out = storage[rd_ptr] combinationally (FWFT).
- Latency: a flit written at edge N is visible on data_out with empty=0 after edge N, i.e. in cycle N+1. No bypass when empty.
- count update: +1 on write only, -1 on read only, unchanged on simultaneous write and read, unchanged on neither.
- Full boundary (count=DEPTH): ret=1 and writes are blocked.
  - If val=1 anyway, the flit is dropped, ovf_err sets to 1 next edge, and pointers and count are unchanged.
  - If rd=1 in that same cycle, the read still proceeds: count becomes DEPTH-1 and ret deasserts next cycle.
- Empty boundary (count=0): empty=1 and reads are blocked.
  - If rd=1, state is unchanged and udf_err sets.
  - A simultaneous val=1 writes normally, giving count=1.
- Pointer wrap: both pointers wrap from DEPTH-1 to 0 with no other side effect. Full and empty are distinguished by count, not by pointer equality.
- Error flags: sticky until rst_n is asserted; they have no effect on data flow.
- Strict FIFO order: flits leave in arrival order with no duplication or reordering.

Test Plan:
- Reset check: assert rst_n=0 mid-stream with count=3 -> immediately count=0, empty=1, ret=0, ovf_err=0, udf_err=0.
- Fill to full: val=1 for 4 cycles with data_in=0xA0..0xA3 and rd=0 -> count goes 1,2,3,4; ret=1 after the 4th edge; empty=0 from cycle 2; data_out=0xA0.
- Overflow: at full, drive val=1 with data_in=0xFF -> ovf_err=1 next cycle, count stays 4, and draining yields 0xA0..0xA3 only.
- Simultaneous at full: count=4, val=1 (a violation), rd=1 -> head 0xA0 popped, count=3, 0xFF not stored, ret=0 next cycle, ovf_err=1.
- Wrap and streaming: val=1 and rd=1 continuously for 10 cycles after a single preload, data 0x00..0x09 -> count holds 1, data_out sequence matches input delayed by 1, pointers wrap twice, ret never asserts.
- Underflow and empty write: count=0, rd=1, val=1 with data_in=0x55 -> udf_err=1, count=1, data_out=0x55 next cycle.
